// File: rtl/id_mem_pkg.sv
// Shared types, default widths and the byte-merge helper for the IDMemory arbiter.
package id_mem_pkg;

   localparam int unsigned ID_MEM_DATA_WIDTH     = 32;
   localparam int unsigned ID_MEM_ADDR_WIDTH     = 10;
   localparam int unsigned ID_MEM_STAT_WIDTH     = 16;
   // Merge helper operates on a wide container so any legal DATA_WIDTH up to 256 fits.
   localparam int unsigned ID_MEM_MAX_DATA_WIDTH = 256;
   localparam int unsigned ID_MEM_MAX_BE_WIDTH   = ID_MEM_MAX_DATA_WIDTH / 8;

   typedef enum logic {
      S_RUN = 1'b0,
      S_RMW = 1'b1
   } state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_e;

   // Take new-data bytes where the strobe is set, old-data bytes elsewhere.
   function automatic logic [ID_MEM_MAX_DATA_WIDTH-1:0] byte_merge(
      input logic [ID_MEM_MAX_DATA_WIDTH-1:0] i_Old,
      input logic [ID_MEM_MAX_DATA_WIDTH-1:0] i_New,
      input logic [ID_MEM_MAX_BE_WIDTH-1:0]   i_Be
   );
      logic [ID_MEM_MAX_DATA_WIDTH-1:0] w_Res;
      w_Res = i_Old;
      for (int b = 0; b < int'(ID_MEM_MAX_BE_WIDTH); b++) begin
         if (i_Be[b]) begin
            w_Res[8*b +: 8] = i_New[8*b +: 8];
         end
      end
      return w_Res;
   endfunction

endpackage

// File: rtl/id_mem_rr_arb.sv
// Two-way round-robin grant for the shared read port; index 0 = fetch, 1 = LSU.
module id_mem_rr_arb (
   input  logic       r_Clk,
   input  logic       r_Rst,
   input  logic       i_En,
   input  logic [1:0] i_Req,
   output logic [1:0] o_Gnt_c
);

   // 1 = LSU has priority on the next contested cycle
   logic r_PtrLs;

   // Grant the pointer's side on contention, otherwise pass the lone request through
   always_comb begin
      o_Gnt_c = 2'b00;
      if (i_En) begin
         if (i_Req == 2'b11) begin
            o_Gnt_c = r_PtrLs ? 2'b10 : 2'b01;
         end else begin
            o_Gnt_c = i_Req;
         end
      end
   end

   // Pointer only moves after a contested grant
   always_ff @(posedge r_Clk or negedge r_Rst) begin
      if (!r_Rst) begin
         r_PtrLs <= 1'b1;
      end else if (i_En && (i_Req == 2'b11)) begin
         r_PtrLs <= ~r_PtrLs;
      end
   end

endmodule

// File: rtl/id_mem_arbiter.sv
// Shares one 1R/1W IDMemory between instruction fetch and the LSU.
// Read port is round-robin arbitrated, full-word stores use the write port
// concurrently with a fetch, partial stores run as a read-modify-write.
// Optional stall counters are built when ID_MEM_ARB_STATS_EN is defined.
module id_mem_arbiter
   import id_mem_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = ID_MEM_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = ID_MEM_ADDR_WIDTH,
   parameter int unsigned STAT_WIDTH = ID_MEM_STAT_WIDTH
) (
   input  logic                    r_Clk,
   input  logic                    r_Rst,
   input  logic                    i_IfValid,
   output logic                    o_IfReady,
   input  logic [ADDR_WIDTH-1:0]   i_IfAddr,
   output logic                    o_IfRspValid,
   output logic [DATA_WIDTH-1:0]   o_IfRspData,
   input  logic                    i_LsValid,
   output logic                    o_LsReady,
   input  logic [ADDR_WIDTH-1:0]   i_LsAddr,
   input  logic                    i_LsWE,
   input  logic [DATA_WIDTH/8-1:0] i_LsBE,
   input  logic [DATA_WIDTH-1:0]   i_LsWD,
   output logic                    o_LsRspValid,
   output logic [DATA_WIDTH-1:0]   o_LsRspData,
   output logic [ADDR_WIDTH-1:0]   o_MemRDAddr,
   input  logic [DATA_WIDTH-1:0]   i_MemRD,
   output logic [ADDR_WIDTH-1:0]   o_MemWRAddr,
   output logic [DATA_WIDTH-1:0]   o_MemWD,
   output logic                    o_MemWE,
   output logic [STAT_WIDTH-1:0]   o_IfStallCnt,
   output logic [STAT_WIDTH-1:0]   o_LsStallCnt
);

   localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

   state_e                r_State;
   logic [ADDR_WIDTH-1:0] r_SavAddr;
   logic [DATA_WIDTH-1:0] r_SavWD;
   logic [BE_WIDTH-1:0]   r_SavBE;
   logic                  r_RdValid;
   owner_e                r_RdOwner;
   logic                  r_LsAck;
   logic [ADDR_WIDTH-1:0] r_WrAddrHold;
   logic [DATA_WIDTH-1:0] r_WrDataHold;

   logic                  w_LsFull;
   logic                  w_LsPartial;
   logic                  w_LsNeedRd;
   logic [1:0]            w_ArbReq;
   logic [1:0]            w_Gnt;
   logic                  w_IfReady;
   logic                  w_LsReady;
   logic                  w_WrEn;
   logic [ADDR_WIDTH-1:0] w_WrAddr;
   logic [DATA_WIDTH-1:0] w_WrData;
   logic [DATA_WIDTH-1:0] w_MergeWD;
   logic                  w_LsRdRsp;

   // Classify the LSU request; BE=0 stores touch neither memory port
   always_comb begin
      w_LsFull    = i_LsWE && (i_LsBE == '1);
      w_LsPartial = i_LsWE && (i_LsBE != '0) && (i_LsBE != '1);
      w_LsNeedRd  = !i_LsWE || w_LsPartial;
   end

   // Read-port requests: same-word read-during-write is blocked for fetch
   always_comb begin
      w_ArbReq = 2'b00;
      if (r_State == S_RUN) begin
         w_ArbReq[1] = i_LsValid && w_LsNeedRd;
         w_ArbReq[0] = i_IfValid && !(i_LsValid && w_LsFull && (i_IfAddr == i_LsAddr));
      end else begin
         w_ArbReq[0] = i_IfValid && (i_IfAddr != r_SavAddr);
      end
   end

   id_mem_rr_arb u_rr_arb (
      .r_Clk   (r_Clk),
      .r_Rst   (r_Rst),
      .i_En    (1'b1),
      .i_Req   (w_ArbReq),
      .o_Gnt_c (w_Gnt)
   );

   assign w_MergeWD = DATA_WIDTH'(byte_merge(ID_MEM_MAX_DATA_WIDTH'(i_MemRD),
                                             ID_MEM_MAX_DATA_WIDTH'(r_SavWD),
                                             ID_MEM_MAX_BE_WIDTH'(r_SavBE)));

   // Handshake and memory-port steering
   always_comb begin
      w_IfReady = w_Gnt[0];
      w_LsReady = 1'b0;
      if (r_State == S_RUN) begin
         w_LsReady = i_LsValid && (w_LsNeedRd ? w_Gnt[1] : 1'b1);
      end
      w_WrEn   = (r_State == S_RMW) || (w_LsReady && w_LsFull);
      w_WrAddr = (r_State == S_RMW) ? r_SavAddr : i_LsAddr;
      w_WrData = (r_State == S_RMW) ? w_MergeWD : i_LsWD;
   end

   assign o_IfReady   = w_IfReady;
   assign o_LsReady   = w_LsReady;
   assign o_MemRDAddr = w_Gnt[1] ? i_LsAddr : (w_Gnt[0] ? i_IfAddr : '0);
   assign o_MemWE     = w_WrEn;
   assign o_MemWRAddr = w_WrEn ? w_WrAddr : r_WrAddrHold;
   assign o_MemWD     = w_WrEn ? w_WrData : r_WrDataHold;

   // Responses: read data comes straight from memory in the cycle after the grant
   assign w_LsRdRsp    = r_RdValid && (r_RdOwner == OWN_LS);
   assign o_IfRspValid = r_RdValid && (r_RdOwner == OWN_IF);
   assign o_IfRspData  = o_IfRspValid ? i_MemRD : '0;
   assign o_LsRspValid = w_LsRdRsp || r_LsAck;
   assign o_LsRspData  = w_LsRdRsp ? i_MemRD : '0;

   // RUN/RMW state machine with response tag, store-ack flag and write holding regs
   always_ff @(posedge r_Clk or negedge r_Rst) begin
      if (!r_Rst) begin
         r_State      <= S_RUN;
         r_SavAddr    <= '0;
         r_SavWD      <= '0;
         r_SavBE      <= '0;
         r_RdValid    <= 1'b0;
         r_RdOwner    <= OWN_IF;
         r_LsAck      <= 1'b0;
         r_WrAddrHold <= '0;
         r_WrDataHold <= '0;
      end else begin
         r_RdValid <= w_Gnt[0] || (w_Gnt[1] && !i_LsWE);
         r_RdOwner <= w_Gnt[1] ? OWN_LS : OWN_IF;
         if (w_WrEn) begin
            r_WrAddrHold <= w_WrAddr;
            r_WrDataHold <= w_WrData;
         end
         case (r_State)
            S_RUN: begin
               r_LsAck <= w_LsReady && i_LsWE && !w_LsPartial;
               if (w_LsReady && w_LsPartial) begin
                  r_SavAddr <= i_LsAddr;
                  r_SavWD   <= i_LsWD;
                  r_SavBE   <= i_LsBE;
                  r_State   <= S_RMW;
               end
            end
            S_RMW: begin
               r_LsAck <= 1'b1;
               r_State <= S_RUN;
            end
            default: begin
               r_LsAck <= 1'b0;
               r_State <= S_RUN;
            end
         endcase
      end
   end

`ifdef ID_MEM_ARB_STATS_EN
   logic [STAT_WIDTH-1:0] r_IfStallCnt;
   logic [STAT_WIDTH-1:0] r_LsStallCnt;

   // Saturating stall counters, cleared only by reset
   always_ff @(posedge r_Clk or negedge r_Rst) begin
      if (!r_Rst) begin
         r_IfStallCnt <= '0;
         r_LsStallCnt <= '0;
      end else begin
         if (i_IfValid && !w_IfReady && (r_IfStallCnt != '1)) begin
            r_IfStallCnt <= r_IfStallCnt + STAT_WIDTH'(1);
         end
         if (i_LsValid && !w_LsReady && (r_LsStallCnt != '1)) begin
            r_LsStallCnt <= r_LsStallCnt + STAT_WIDTH'(1);
         end
      end
   end

   assign o_IfStallCnt = r_IfStallCnt;
   assign o_LsStallCnt = r_LsStallCnt;
`else
   assign o_IfStallCnt = '0;
   assign o_LsStallCnt = '0;
`endif

endmodule
